// File: rtl/seq_decoder_pkg.sv
// rtl/seq_decoder_pkg.sv - shared state and mode encodings for seq_decoder
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// rtl/seq_decoder_onehot_dec.sv - combinational SEL_W to 2**SEL_W one-hot decode
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - registered one-hot decoder with DIRECT/SCAN modes (option: SEQ_DECODER_SCAN_DOWN_EN)
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
`ifdef SEQ_DECODER_SCAN_DOWN_EN
    input  logic                  dir,
`endif
    output logic [(2**SEL_W)-1:0] out,
    output logic                  valid,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int N_OUT = 2**SEL_W;
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    generate
        if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
            $error("seq_decoder: DWELL must be in 1..65535");
        end
    endgenerate

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [SEL_W-1:0]   idx_n;
    logic [N_OUT-1:0]   out_n;
    logic               valid_n;
    logic               wrap_n;
    logic [N_OUT-1:0]   dec_out;
    logic               scan_down;
    logic               scan_down_n;

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .sel    (sel),
        .onehot (dec_out)
    );

`ifdef SEQ_DECODER_SCAN_DOWN_EN
    logic dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= scan_down_n;
        end
    end

    assign scan_down = dir_q;
`else
    assign scan_down = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            out   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            out   <= out_n;
            valid <= valid_n;
            wrap  <= wrap_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        out_n       = out;
        valid_n     = valid;
        wrap_n      = 1'b0;
        scan_down_n = scan_down;

        if (!en) begin
            // idx is deliberately retained so software can see the last position
            state_n = IDLE;
            cnt_n   = '0;
            out_n   = '0;
            valid_n = 1'b0;
        end else if (load) begin
            idx_n   = sel;
            cnt_n   = '0;
            out_n   = dec_out;
            valid_n = 1'b1;
            state_n = (mode == MODE_SCAN) ? SCAN : HOLD;
`ifdef SEQ_DECODER_SCAN_DOWN_EN
            scan_down_n = dir;
`endif
        end else if (state == SCAN) begin
            if (cnt == DWELL_LAST) begin
                cnt_n = '0;
                if (scan_down) begin
                    idx_n  = idx - 1'b1;
                    out_n  = {out[0], out[N_OUT-1:1]};
                    wrap_n = (idx == '0);
                end else begin
                    idx_n  = idx + 1'b1;
                    out_n  = {out[N_OUT-2:0], out[N_OUT-1]};
                    wrap_n = (&idx);
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
- Parametrised registered SEL_W-to-2^SEL_W one-hot decoder.
- Two modes:
  - DIRECT: decodes a loaded select value and holds it.
  - SCAN: steps the one-hot output through all positions, each held for DWELL cycles.
- Intended for multiplexed display digit/row drivers and bank selects.
- Generalises the 2x4 gate decoder with width, registered output, mode FSM and scan counter.

Parameters:
- SEL_W, 2, select width; N_OUT = 2**SEL_W outputs (localparam, not overridable).
- DWELL, 4, cycles each output stays active in SCAN mode; legal range 1..65535; DWELL < 1 is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; 0 forces IDLE
- load  in  1  one-cycle strobe; captures sel and mode
- mode  in  1  0 = DIRECT, 1 = SCAN; sampled only with load
- sel  in  SEL_W  select value (DIRECT) or scan start index (SCAN)
- out  out  N_OUT  registered one-hot output; all-zero when idle
- valid  out  1  1 when out is driving a one-hot value
- idx  out  SEL_W  binary index of the active output
- wrap  out  1  one-cycle pulse when scan index wraps from N_OUT-1 to 0

Behaviour:
- Reset, asynchronous on rst_n low:
  - out=0, valid=0, idx=0, wrap=0.
  - Dwell counter=0, state=IDLE.
  - Takes effect immediately, including mid-scan.
- States:
  - IDLE: out=0, valid=0.
  - HOLD: DIRECT mode, output static.
  - SCAN: auto-step.
- Priority each cycle: en=0 > load > scan stepping.
- en=0 in any state: next cycle state=IDLE; out, valid, wrap and the dwell counter clear; idx keeps its value.
- load=1 with en=1, any state:
  - idx <= sel and dwell counter <= 0.
  - Next state HOLD if mode=0, SCAN if mode=1.
  - out = one-hot(sel) and valid=1 from the cycle after load (latency 1).
- HOLD without load: out, idx, valid unchanged.
- SCAN without load:
  - Dwell counter increments each cycle.
  - When it equals DWELL-1: counter <= 0, idx <= idx+1 modulo N_OUT, out rotates left by one (bit N_OUT-1 to bit 0).
  - wrap=1 in the same cycle out becomes bit 0 via rotation, 0 otherwise.
- Loading sel=0 in SCAN does not pulse wrap.
- DWELL=1: idx advances every cycle.
- Invariant: out == (valid ? 1<<idx : 0), checked every cycle.
- IDLE with en=1 and no load: stays IDLE.
- Dwell counter width: max(1, $clog2(DWELL)).

Optional Feature:
- Macro: SEQ_DECODER_SCAN_DOWN_EN.
- Defined:
  - Adds input port dir (1 bit), sampled with load.
  - dir=1 makes SCAN decrement idx modulo N_OUT and rotate out right.
  - wrap pulses on the 0 to N_OUT-1 transition.
- Undefined: port absent; SCAN always increments.

Decomposition:
- Package seq_decoder_pkg holds the state encoding constants IDLE=2'd0, HOLD=2'd1, SCAN=2'd2, and the MODE_DIRECT/MODE_SCAN constants.
- One sub-module, onehot_dec (combinational SEL_W to N_OUT decode), is instanced for load-time one-hot generation.
- FSM, dwell counter and rotation stay in the top.

Test Plan (SEL_W=2, DWELL=3 unless noted):
- Reset: rst_n=0 mid-SCAN -> same time step out=0000, valid=0, idx=0, wrap=0; after release with en=1 and no load -> stays IDLE.
- DIRECT: en=1, load, mode=0, sel=2 -> next cycle out=0100, valid=1, idx=2; holds 10 cycles; load sel=3 -> out=1000 next cycle.
- SCAN: load mode=1, sel=2 -> out sequence 0100 for 3 cycles, 1000 for 3 cycles, then 0001 with wrap=1 for exactly one cycle, then 0010.
- Priority: en=0 and load=1 in the same cycle -> next cycle IDLE, out=0000, valid=0, idx keeps its prior value; load mid-dwell in SCAN -> counter restarts and the new index holds a full 3 cycles.
- DWELL=1, SEL_W=3: load mode=1, sel=7 -> out=0x80 then 0x01 with wrap=1 on the next cycle; 8-cycle period thereafter.
- SEQ_DECODER_SCAN_DOWN_EN defined: dir=1, sel=1 -> 0010 then 0001 then 1000 with wrap=1.
